// File: rtl/count_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : count_pulse_gen
// Brief    : Synchronised, debounced push-button to one-cycle count enable,
//            with optional auto-repeat while the button is held.
// Revision : 1.0 - initial release
// ============================================================================
module count_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 16,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic repeat_en,
  output logic pulse,
  output logic btn_level
);

  localparam logic [CNT_W-1:0] c_DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_DB_PRESS   = 3'd1,
    S_HELD       = 3'd2,
    S_REPEAT     = 3'd3,
    S_DB_RELEASE = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_s1;
  logic             r_btn_s;
  logic             r_pulse;
  logic             r_btn_level;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1    <= 1'b0;
      r_btn_s <= 1'b0;
    end else begin
      r_s1    <= btn_in;
      r_btn_s <= r_s1;
    end
  end

  // Every state change clears r_cnt; release always wins over repeat/terminal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pulse     <= 1'b0;
      r_btn_level <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_btn_s) begin
            r_state <= S_DB_PRESS;
            r_cnt   <= '0;
          end
        end
        S_DB_PRESS: begin
          if (!r_btn_s) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == c_DB_LAST) begin
            r_state     <= S_HELD;
            r_cnt       <= '0;
            r_pulse     <= 1'b1;
            r_btn_level <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HELD: begin
          if (!r_btn_s) begin
            r_state <= S_DB_RELEASE;
            r_cnt   <= '0;
          end else if (repeat_en && (r_cnt == c_HOLD_LAST)) begin
            r_state <= S_REPEAT;
            r_cnt   <= '0;
            r_pulse <= 1'b1;
          end else if (r_cnt != c_HOLD_LAST) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_REPEAT: begin
          if (!r_btn_s) begin
            r_state <= S_DB_RELEASE;
            r_cnt   <= '0;
          end else if (!repeat_en) begin
            r_state <= S_HELD;
            r_cnt   <= '0;
          end else if (r_cnt == c_REP_LAST) begin
            r_cnt   <= '0;
            r_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DB_RELEASE: begin
          if (r_btn_s) begin
            r_state <= S_HELD;
            r_cnt   <= '0;
          end else if (r_cnt == c_DB_LAST) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_btn_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cnt       <= '0;
          r_btn_level <= 1'b0;
        end
      endcase
    end
  end

  assign pulse     = r_pulse;
  assign btn_level = r_btn_level;

endmodule
`default_nettype wire

// File: doc/count_pulse_gen.md
# count_pulse_gen

Debounced single-pulse generator that produces the one-cycle count-enable (`x`) for the 2-bit counter stage from a raw push-button. It sits directly upstream of the counter. It synchronises the asynchronous button, filters bounce, and emits exactly one `pulse` per confirmed press. An optional auto-repeat emits further pulses while the button is held.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronised samples required to accept a press or release (≥2).
- `HOLD_CYCLES`, 64: cycles held after the first pulse before auto-repeat starts (≥2).
- `REPEAT_CYCLES`, 16: period between auto-repeat pulses (≥2).
- `CNT_W`, 8: internal counter width; must hold max(parameters)−1.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset.
- `btn_in`  input  1  raw button, asynchronous to `clk`, active-high.
- `repeat_en`  input  1  enables auto-repeat; synchronous to `clk`.
- `pulse`  output  1  registered one-cycle count enable; drives the counter's `x`.
- `btn_level`  output  1  registered debounced button level.

## Operation
- 2-FF synchroniser: `btn_in` → `s1` → `btn_s`. Only `btn_s` is used by the FSM.
- A single counter `cnt` is shared by all states and is cleared on every state entry.
- States and transitions (evaluated each rising edge):
  - IDLE: if `btn_s`=1, go to DB_PRESS.
  - DB_PRESS: if `btn_s`=0, go to IDLE (bounce, no pulse). Else if `cnt`=DEBOUNCE_CYCLES−1, go to HELD and set `pulse`. Else `cnt`+1.
  - HELD: if `btn_s`=0, go to DB_RELEASE. Else if `repeat_en`=1 and `cnt`=HOLD_CYCLES−1, go to REPEAT and set `pulse`. Else `cnt`+1, saturating when `repeat_en`=0.
  - REPEAT: if `btn_s`=0, go to DB_RELEASE. Else if `repeat_en`=0, go to HELD with no pulse. Else if `cnt`=REPEAT_CYCLES−1, set `pulse` and clear `cnt`. Else `cnt`+1.
  - DB_RELEASE: if `btn_s`=1, go to HELD (release bounce, no pulse; hold timer restarts). Else if `cnt`=DEBOUNCE_CYCLES−1, go to IDLE. Else `cnt`+1.
- `pulse` is high for exactly one cycle per pulse event and is never high on two consecutive cycles.
- `btn_level`=1 in HELD, REPEAT and DB_RELEASE; 0 in IDLE and DB_PRESS. It is registered from the next state.
- Priority within a state: release detection (`btn_s`=0) > `repeat_en` change > terminal-count action.

## Timing
- Reset (`reset`=0) is asynchronous and takes effect immediately:
  - `s1`, `btn_s`, `pulse`, `btn_level`, `cnt` = 0; state = IDLE.
  - If reset asserts while `pulse`=1, `pulse` drops at once.
- Deasserting reset while `btn_in`=1 is treated as a fresh press; full debounce applies.
- Press latency: `pulse` goes high after the (DEBOUNCE_CYCLES+3)th rising edge, counting the first edge that samples `btn_in`=1. This assumes `btn_in` is stable throughout.
- `btn_level` rises on the same edge as the first `pulse`.
- First repeat pulse: HOLD_CYCLES edges after the first pulse edge. Subsequent repeat pulses every REPEAT_CYCLES edges.
- Release latency: `btn_level` falls DEBOUNCE_CYCLES+3 edges after the first edge that samples `btn_in`=0.
- A press glitch shorter than DEBOUNCE_CYCLES samples of `btn_s` produces no `pulse` and no change in `btn_level`.
- `repeat_en` rising while in HELD with `cnt` already saturated: go to REPEAT with `pulse` on the next edge.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=3.
- **Reset:** assert `reset`=0 mid-DB_PRESS and mid-pulse → `pulse`, `btn_level` = 0 immediately; after release, `btn_in`=0 for 20 cycles → no pulse.
- **Clean press:** `btn_in` 0→1 held, `repeat_en`=0 → single `pulse` at edge 7; `btn_level`=1 from edge 7; no further pulses over 100 cycles.
- **Bounce:** `btn_in` toggles 1,0,1,0 every 2 cycles, then stays 1 → no pulse during the bounce; exactly one pulse 7 edges after the final rise.
- **Auto-repeat:** press held, `repeat_en`=1 → pulses at edges 7, 15, 18, 21, …; drop `repeat_en` → pulses stop, `btn_level` stays 1.
- **Release glitch:** while HELD, `btn_in`=0 for 3 cycles, then 1 → no pulse, `btn_level` stays 1. Then a genuine release → `btn_level`=0 at edge 7 after the fall.
- **Counter integration:** drive the 2-bit counter's `x` from `pulse` and perform 5 clean presses → counter output sequence 1,2,3,0,1; the counter's carry output `z`, which is set on the 3→0 step, goes to 1.
